// File: rtl/lc3_pkg.sv
// lc3_pkg: shared definitions for the LC-3 memory access block.
//  - Default memory-mapped I/O register addresses (KBSR/KBDR/DSR/DDR).
//  - Default external-access timeout.
//  - State encoding of the memory access FSM.
package lc3_pkg;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  localparam int TIMEOUT_DEFAULT = 64;

  // IDLE : waiting for mio_en, MAR/MDR loadable
  // START: r_w latched, MAR decoded, MMIO accesses complete here
  // EXT  : external request outstanding, timeout counter running
  // DONE : mem_r pulse
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    EXT   = 2'd2,
    DONE  = 2'd3
  } mem_state_t;

endpackage

// File: rtl/lc3_mmio_regs.sv
// lc3_mmio_regs: keyboard and display device registers.
//  Ports:
//   clk, reset      clock, asynchronous active-high reset
//   addr            current MAR value, decoded against the four register addresses
//   wdata           low byte of MDR, the character written to DDR
//   rd, wr          one-cycle access strobes (only asserted on a decode hit)
//   hit             addr matches one of the four registers
//   rdata           read value for the addressed register
//   kb_valid/kb_data    keystroke input
//   disp_valid/disp_data  one-cycle character strobe to the display
//   disp_ack        display consumed the character
module lc3_mmio_regs
  import lc3_pkg::*;
#(
  parameter logic [15:0] KBSR_A = KBSR_ADDR,
  parameter logic [15:0] KBDR_A = KBDR_ADDR,
  parameter logic [15:0] DSR_A  = DSR_ADDR,
  parameter logic [15:0] DDR_A  = DDR_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        rd,
  input  logic        wr,
  output logic        hit,
  output logic [15:0] rdata,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ack
);

  logic       kbsr_rdy;
  logic [7:0] kbdr;
  logic       dsr_rdy;

  logic sel_kbsr, sel_kbdr, sel_dsr, sel_ddr;
  logic rd_kbdr, wr_ddr;

  // Full 16-bit compares: no aliasing of nearby addresses.
  assign sel_kbsr = (addr == KBSR_A);
  assign sel_kbdr = (addr == KBDR_A);
  assign sel_dsr  = (addr == DSR_A);
  assign sel_ddr  = (addr == DDR_A);
  assign hit      = sel_kbsr | sel_kbdr | sel_dsr | sel_ddr;

  assign rd_kbdr = rd & sel_kbdr;
  assign wr_ddr  = wr & sel_ddr;

  always_comb begin
    rdata = 16'h0000;
    if (sel_kbsr)      rdata = {kbsr_rdy, 15'b0};
    else if (sel_kbdr) rdata = {8'b0, kbdr};
    else if (sel_dsr)  rdata = {dsr_rdy, 15'b0};
  end

  // Keyboard side. A new keystroke in the same cycle as a KBDR read wins:
  // the read returns the old byte, and the ready flag stays set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbsr_rdy <= 1'b0;
      kbdr     <= 8'h00;
    end else if (kb_valid) begin
      kbsr_rdy <= 1'b1;
      kbdr     <= kb_data;
    end else if (rd_kbdr) begin
      kbsr_rdy <= 1'b0;
    end
  end

  // Display side. A DDR write in the same cycle as disp_ack wins (busy).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dsr_rdy    <= 1'b1;
      disp_valid <= 1'b0;
      disp_data  <= 8'h00;
    end else begin
      disp_valid <= wr_ddr;
      if (wr_ddr) begin
        disp_data <= wdata;
        dsr_rdy   <= 1'b0;
      end else if (disp_ack) begin
        dsr_rdy <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/lc3_mem_access.sv
// lc3_mem_access: memory-side responder for the LC-3 MAR/MDR interface.
//  Holds MAR and MDR, runs one read or write per mio_en request and returns
//  a one-cycle mem_r. Addresses of the four MMIO registers are serviced by
//  lc3_mmio_regs; everything else goes out on a req/ack memory port with a
//  timeout that aborts the access and sets a sticky bus_err.
//  Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   bus_in, ld_mar, ld_mdr     datapath bus and register loads (IDLE only)
//   mio_en, r_w                access request and direction (1 = write)
//   mdr_out, mem_r, bus_err    MDR contents, completion pulse, timeout flag
//   mem_addr/mem_wdata/mem_req/mem_we, mem_rdata/mem_ack   external memory port
//   kb_valid/kb_data           keystroke input
//   disp_valid/disp_data/disp_ack  display output
//   state                      current FSM state (observability)
//  Handshakes: mem_req is held, with mem_addr/mem_we/mem_wdata stable, until
//  the first cycle mem_ack is seen high; that cycle completes the transfer and
//  mem_rdata is captured with it. mio_en is held by the requester until mem_r.
module lc3_mem_access
  import lc3_pkg::*;
#(
  parameter int          TIMEOUT = TIMEOUT_DEFAULT,
  parameter logic [15:0] KBSR_A  = KBSR_ADDR,
  parameter logic [15:0] KBDR_A  = KBDR_ADDR,
  parameter logic [15:0] DSR_A   = DSR_ADDR,
  parameter logic [15:0] DDR_A   = DDR_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bus_in,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        mio_en,
  input  logic        r_w,
  output logic [15:0] mdr_out,
  output logic        mem_r,
  output logic        bus_err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_req,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ack,
  output mem_state_t  state
);

  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  mem_state_t    state_q, state_d;
  logic [15:0]   mar, mdr;
  logic          we_q;
  logic          err_q;
  logic [CW-1:0] cnt;

  logic          mmio_hit;
  logic [15:0]   mmio_rdata;
  logic          mmio_go;
  logic          timed_out;

  assign mmio_go   = (state_q == START) && mmio_hit;
  // Last EXT cycle without an ack: the request has been up TIMEOUT cycles.
  assign timed_out = (state_q == EXT) && !mem_ack && (cnt == CNT_LAST);

  lc3_mmio_regs #(
    .KBSR_A (KBSR_A),
    .KBDR_A (KBDR_A),
    .DSR_A  (DSR_A),
    .DDR_A  (DDR_A)
  ) u_mmio (
    .clk        (clk),
    .reset      (reset),
    .addr       (mar),
    .wdata      (mdr[7:0]),
    .rd         (mmio_go & ~we_q),
    .wr         (mmio_go & we_q),
    .hit        (mmio_hit),
    .rdata      (mmio_rdata),
    .kb_valid   (kb_valid),
    .kb_data    (kb_data),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .disp_ack   (disp_ack)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (mio_en) state_d = START;
      START: state_d = mmio_hit ? DONE : EXT;
      EXT:   if (mem_ack || timed_out) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mar   <= 16'h0000;
      mdr   <= 16'h0000;
      we_q  <= 1'b0;
      err_q <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ld_mar) mar <= bus_in;
          if (ld_mdr) mdr <= bus_in;
          if (mio_en) we_q <= r_w;
        end
        START: begin
          cnt <= '0;
          if (mmio_hit && !we_q) mdr <= mmio_rdata;
        end
        EXT: begin
          if (mem_ack) begin
            if (!we_q) mdr <= mem_rdata;
          end else if (timed_out) begin
            err_q <= 1'b1;
            if (!we_q) mdr <= 16'h0000;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Request is a decode of the state register, so an asynchronous reset
  // drops it immediately.
  assign mem_req   = (state_q == EXT);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mar;
  assign mem_wdata = mdr;
  assign mem_r     = (state_q == DONE);
  assign mdr_out   = mdr;
  assign bus_err   = err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_lc3_mem_access.sv
module tb_lc3_mem_access;
  import lc3_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bus_in;
  logic        ld_mar, ld_mdr, mio_en, r_w;
  logic [15:0] mdr_out;
  logic        mem_r, bus_err;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        disp_ack;
  mem_state_t  state;

  lc3_mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mio_en(mio_en), .r_w(r_w), .mdr_out(mdr_out), .mem_r(mem_r), .bus_err(bus_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .kb_valid(kb_valid), .kb_data(kb_data),
    .disp_valid(disp_valid), .disp_data(disp_data), .disp_ack(disp_ack), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  disp_q[$];

  // external memory model controls
  logic        ack_en = 1'b0;
  int          ack_delay = 0;
  logic [15:0] ack_data = 16'h0000;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // external memory responder
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req && ack_en) begin
        if (wcnt == ack_delay) begin
          mem_ack = 1'b1;
          mem_rdata = ack_data;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // scoreboard monitors
  always @(negedge clk) begin
    if (mem_r) begin
      if (exp_q.size() == 0) check("unexpected_mem_r", 16'h1, 16'h0);
      else check("mdr_on_mem_r", mdr_out, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (disp_valid) begin
      if (disp_q.size() == 0) check("unexpected_disp_valid", 16'h1, 16'h0);
      else check("disp_data", {8'h00, disp_data}, {8'h00, disp_q.pop_front()});
    end
  end

  // driver tasks
  task automatic set_mar(input logic [15:0] v);
    @(negedge clk); bus_in = v; ld_mar = 1'b1;
    @(negedge clk); ld_mar = 1'b0;
  endtask

  task automatic set_mdr(input logic [15:0] v);
    @(negedge clk); bus_in = v; ld_mdr = 1'b1;
    @(negedge clk); ld_mdr = 1'b0;
  endtask

  task automatic kb_pulse(input logic [7:0] v);
    @(negedge clk); kb_valid = 1'b1; kb_data = v;
    @(negedge clk); kb_valid = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge clk); disp_ack = 1'b1;
    @(negedge clk); disp_ack = 1'b0;
  endtask

  // One access. kb_hit drives a keystroke during the START cycle.
  task automatic do_access(input logic rw, input logic ext, input logic [15:0] exp_addr,
                           input logic [15:0] exp_mdr, input logic kb_hit,
                           input logic [7:0] kb_v, output int req_cycles);
    int  lat;
    bit  seen, done;
    exp_q.push_back(exp_mdr);
    @(negedge clk); r_w = rw; mio_en = 1'b1;
    lat = 0; req_cycles = 0; seen = 0; done = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (kb_hit && lat == 1) begin kb_valid = 1'b1; kb_data = kb_v; end
      if (kb_hit && lat == 2) kb_valid = 1'b0;
      if (mem_req) begin
        req_cycles++;
        if (!seen) begin
          check("mem_addr", mem_addr, exp_addr);
          check("mem_we", {15'b0, mem_we}, {15'b0, rw});
          if (rw) check("mem_wdata", mem_wdata, exp_mdr);
        end
        seen = 1;
      end
      if (mem_r) done = 1;
    end
    mio_en = 1'b0; r_w = 1'b0; kb_valid = 1'b0;
    if (!done) check("mem_r_timeout", 16'h0, 16'h1);
    else begin
      if (!ext) begin
        check("mmio_latency", 16'(lat), 16'd2);
        check("mmio_no_req", 16'(req_cycles), 16'd0);
      end
      @(negedge clk);
      check("mem_r_one_cycle", {15'b0, mem_r}, 16'h0);
    end
  endtask

  initial begin
    int rc;
    reset = 1'b1; bus_in = 16'h0; ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0;
    kb_valid = 0; kb_data = 8'h00; disp_ack = 0;
    repeat (3) @(negedge clk);
    check("rst_mdr", mdr_out, 16'h0000);
    check("rst_mem_r", {15'b0, mem_r}, 16'h0);
    check("rst_bus_err", {15'b0, bus_err}, 16'h0);
    check("rst_mem_req", {15'b0, mem_req}, 16'h0);
    check("rst_mem_we", {15'b0, mem_we}, 16'h0);
    check("rst_disp_valid", {15'b0, disp_valid}, 16'h0);
    check("rst_state", 16'(state), 16'(IDLE));
    reset = 1'b0;

    // external read and write
    ack_en = 1'b1; ack_delay = 3; ack_data = 16'hBEEF;
    set_mar(16'h3000); do_access(1'b0, 1'b1, 16'h3000, 16'hBEEF, 0, 8'h0, rc);
    set_mar(16'h4000); set_mdr(16'h1234);
    do_access(1'b1, 1'b1, 16'h4000, 16'h1234, 0, 8'h0, rc);

    // keyboard
    kb_pulse(8'h41);
    set_mar(16'hFE00); do_access(1'b0, 1'b0, 16'h0, 16'h8000, 0, 8'h0, rc);
    set_mar(16'hFE02); do_access(1'b0, 1'b0, 16'h0, 16'h0041, 0, 8'h0, rc);
    set_mar(16'hFE00); do_access(1'b0, 1'b0, 16'h0, 16'h0000, 0, 8'h0, rc);
    // write to KBSR is ignored
    set_mdr(16'hFFFF); do_access(1'b1, 1'b0, 16'h0, 16'hFFFF, 0, 8'h0, rc);
    do_access(1'b0, 1'b0, 16'h0, 16'h0000, 0, 8'h0, rc);

    // display
    set_mar(16'hFE04); do_access(1'b0, 1'b0, 16'h0, 16'h8000, 0, 8'h0, rc);
    set_mdr(16'h0058); set_mar(16'hFE06);
    disp_q.push_back(8'h58);
    do_access(1'b1, 1'b0, 16'h0, 16'h0058, 0, 8'h0, rc);
    set_mar(16'hFE04); do_access(1'b0, 1'b0, 16'h0, 16'h0000, 0, 8'h0, rc);
    ack_pulse();
    do_access(1'b0, 1'b0, 16'h0, 16'h8000, 0, 8'h0, rc);
    set_mar(16'hFE06); do_access(1'b0, 1'b0, 16'h0, 16'h0000, 0, 8'h0, rc);

    // keystroke in the same cycle as a KBDR read: old data, new key kept
    kb_pulse(8'h42);
    set_mar(16'hFE02); do_access(1'b0, 1'b0, 16'h0, 16'h0042, 1, 8'h43, rc);
    set_mar(16'hFE00); do_access(1'b0, 1'b0, 16'h0, 16'h8000, 0, 8'h0, rc);
    set_mar(16'hFE02); do_access(1'b0, 1'b0, 16'h0, 16'h0043, 0, 8'h0, rc);

    // timeout
    ack_en = 1'b0;
    set_mdr(16'hAAAA); set_mar(16'h5000);
    do_access(1'b0, 1'b1, 16'h5000, 16'h0000, 0, 8'h0, rc);
    check("timeout_req_cycles", 16'(rc), 16'(TO));
    check("bus_err_set", {15'b0, bus_err}, 16'h1);

    // bus_err is sticky over a good access
    ack_en = 1'b1; ack_delay = 0; ack_data = 16'hCAFE;
    set_mar(16'h5002); do_access(1'b0, 1'b1, 16'h5002, 16'hCAFE, 0, 8'h0, rc);
    check("bus_err_sticky", {15'b0, bus_err}, 16'h1);

    // reset during EXT
    ack_en = 1'b0;
    set_mar(16'h6000);
    @(negedge clk); mio_en = 1'b1; r_w = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_req", {15'b0, mem_req}, 16'h1);
    check("pre_reset_state", 16'(state), 16'(EXT));
    #2 reset = 1'b1;
    #1;
    check("async_reset_req", {15'b0, mem_req}, 16'h0);
    check("async_reset_state", 16'(state), 16'(IDLE));
    check("async_reset_bus_err", {15'b0, bus_err}, 16'h0);
    check("async_reset_mdr", mdr_out, 16'h0000);
    check("async_reset_mem_r", {15'b0, mem_r}, 16'h0);
    mio_en = 1'b0;
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);

    check("exp_q_empty", 16'(exp_q.size()), 16'd0);
    check("disp_q_empty", 16'(disp_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
